// File: rtl/complex_mult_pipe_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : complex_mult_pipe_if
//  Description : Operand/result handshake bundle for complex_mult_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
interface complex_mult_pipe_if #(
  parameter int W = 32
);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] ar;
  logic signed [W-1:0] ai;
  logic signed [W-1:0] br;
  logic signed [W-1:0] bi;
  logic                conj_b;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] cr;
  logic signed [W-1:0] ci;
  logic [1:0]          ovf;

  modport slave (
    input  in_valid, ar, ai, br, bi, conj_b, out_ready,
    output in_ready, out_valid, cr, ci, ovf
  );

  modport master (
    output in_valid, ar, ai, br, bi, conj_b, out_ready,
    input  in_ready, out_valid, cr, ci, ovf
  );
endinterface
`default_nettype wire

// File: rtl/complex_mult_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : complex_mult_pipe
//  Description : Pipelined signed fixed-point complex multiplier, A*B or
//                A*conj(B), with a global stall and per-result overflow flags.
//                Define CMULT_SAT_EN to saturate out-of-range results
//                (default build wraps them).
//  Revision    : 1.0 - initial release
// ============================================================================
module complex_mult_pipe #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  complex_mult_pipe_if.slave  bus
);
  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;

  logic                 w_adv;

  logic                 r_v0, r_v1, r_v2, r_v3;
  logic                 r_c0, r_c1;
  logic signed [W-1:0]  r_ar, r_ai, r_br, r_bi;
  logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  logic signed [SW-1:0] r_sum_re, r_sum_im;
  logic signed [W-1:0]  r_cr, r_ci;
  logic [1:0]           r_ovf;

  logic signed [PW-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x;
  logic signed [SW-1:0] w_rr, w_ii, w_ri, w_ir;
  logic signed [SW-1:0] w_sum_re, w_sum_im;
  logic signed [SW-1:0] w_sc_re, w_sc_im;
  logic                 w_ovf_re, w_ovf_im;
  logic [W-1:0]         w_res_re, w_res_im;

  // One enable moves every stage together, so bubbles keep their slot.
  assign w_adv        = !r_v3 || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Operands are flopped ahead of the multipliers so products start from registers.
  assign w_ar_x = {{W{r_ar[W-1]}}, r_ar};
  assign w_ai_x = {{W{r_ai[W-1]}}, r_ai};
  assign w_br_x = {{W{r_br[W-1]}}, r_br};
  assign w_bi_x = {{W{r_bi[W-1]}}, r_bi};

  always_comb begin
    w_rr     = {r_p_rr[PW-1], r_p_rr};
    w_ii     = {r_p_ii[PW-1], r_p_ii};
    w_ri     = {r_p_ri[PW-1], r_p_ri};
    w_ir     = {r_p_ir[PW-1], r_p_ir};
    w_sum_re = r_c1 ? (w_rr + w_ii) : (w_rr - w_ii);
    w_sum_im = r_c1 ? (w_ir - w_ri) : (w_ri + w_ir);
  end

  // Floor scaling; the value fits W bits only if bits [SW-1:W-1] are all equal.
  always_comb begin
    w_sc_re  = r_sum_re >>> FRAC;
    w_sc_im  = r_sum_im >>> FRAC;
    w_ovf_re = !((&w_sc_re[SW-1:W-1]) || !(|w_sc_re[SW-1:W-1]));
    w_ovf_im = !((&w_sc_im[SW-1:W-1]) || !(|w_sc_im[SW-1:W-1]));
`ifdef CMULT_SAT_EN
    w_res_re = w_sc_re[W-1:0];
    w_res_im = w_sc_im[W-1:0];
    if (w_ovf_re)
      w_res_re = w_sc_re[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    if (w_ovf_im)
      w_res_im = w_sc_im[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    w_res_re = w_sc_re[W-1:0];
    w_res_im = w_sc_im[W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_v3     <= 1'b0;
      r_c0     <= 1'b0;
      r_c1     <= 1'b0;
      r_ar     <= '0;
      r_ai     <= '0;
      r_br     <= '0;
      r_bi     <= '0;
      r_p_rr   <= '0;
      r_p_ii   <= '0;
      r_p_ri   <= '0;
      r_p_ir   <= '0;
      r_sum_re <= '0;
      r_sum_im <= '0;
      r_cr     <= '0;
      r_ci     <= '0;
      r_ovf    <= 2'b00;
    end else if (w_adv) begin
      r_v0     <= bus.in_valid;
      r_c0     <= bus.conj_b;
      r_ar     <= bus.ar;
      r_ai     <= bus.ai;
      r_br     <= bus.br;
      r_bi     <= bus.bi;

      r_v1     <= r_v0;
      r_c1     <= r_c0;
      r_p_rr   <= w_ar_x * w_br_x;
      r_p_ii   <= w_ai_x * w_bi_x;
      r_p_ri   <= w_ar_x * w_bi_x;
      r_p_ir   <= w_ai_x * w_br_x;

      r_v2     <= r_v1;
      r_sum_re <= w_sum_re;
      r_sum_im <= w_sum_im;

      r_v3     <= r_v2;
      r_cr     <= w_res_re;
      r_ci     <= w_res_im;
      r_ovf    <= {w_ovf_im, w_ovf_re};
    end
  end

  assign bus.out_valid = r_v3;
  assign bus.cr        = r_cr;
  assign bus.ci        = r_ci;
  assign bus.ovf       = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_complex_mult_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_complex_mult_pipe
//  Description : Directed and scoreboard bench for complex_mult_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_complex_mult_pipe;
  localparam int W    = 32;
  localparam int FRAC = 16;
  localparam logic signed [64:0] MAXV = 65'sd2147483647;
  localparam logic signed [64:0] MINV = -65'sd2147483648;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  complex_mult_pipe_if #(.W(W)) bus ();
  complex_mult_pipe #(.W(W), .FRAC(FRAC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          vectors     = 0;
  int          miscompares = 0;
  logic [65:0] sb[$];
  bit          last_acc;

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] fit(input logic signed [64:0] v);
    logic o;
    o = (v > MAXV) || (v < MINV);
`ifdef CMULT_SAT_EN
    if (o) return {1'b1, (v < 0) ? 32'h80000000 : 32'h7FFFFFFF};
`endif
    return {o, v[31:0]};
  endfunction

  function automatic logic [65:0] model(input logic signed [W-1:0] ar, ai, br, bi, input logic cj);
    logic signed [64:0] prr, pii, pri, pir, re, im;
    logic [32:0] fr, fi;
    prr = 65'(ar) * 65'(br);
    pii = 65'(ai) * 65'(bi);
    pri = 65'(ar) * 65'(bi);
    pir = 65'(ai) * 65'(br);
    re  = cj ? (prr + pii) : (prr - pii);
    im  = cj ? (pir - pri) : (pri + pir);
    fr  = fit(re >>> FRAC);
    fi  = fit(im >>> FRAC);
    return {fi[32], fr[32], fi[31:0], fr[31:0]};
  endfunction

  // One clock: record accepted sets, score delivered results, advance to next negedge.
  task automatic step();
    #1;
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) sb.push_back(model(bus.ar, bus.ai, bus.br, bus.bi, bus.conj_b));
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_out", {65'd0, bus.out_valid}, 66'd0);
      else                check("result", {bus.ovf, bus.ci, bus.cr}, sb.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return r;
      1:       return {{12{r[19]}}, r[19:0]};
      2:       return r[0] ? 32'h7FFFFFFF : 32'h80000000;
      default: return {{24{r[7]}}, r[7:0]};
    endcase
  endfunction

  task automatic drive_rand();
    bus.ar     = rnd_op();
    bus.ai     = rnd_op();
    bus.br     = rnd_op();
    bus.bi     = rnd_op();
    bus.conj_b = $urandom_range(0, 1);
  endtask

  task automatic directed(input string tag, input logic [31:0] ar, ai, br, bi, input logic cj,
                          input logic [31:0] ecr, eci, input logic [1:0] eovf);
    bus.ar = ar; bus.ai = ai; bus.br = br; bus.bi = bi; bus.conj_b = cj;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    check({tag, "_in_ready"}, {65'd0, bus.in_ready}, 66'd1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_early_valid"}, {65'd0, bus.out_valid}, 66'd0);
      step();
    end
    check({tag, "_latency_valid"}, {65'd0, bus.out_valid}, 66'd1);
    check({tag, "_value"}, {bus.ovf, bus.ci, bus.cr}, {eovf, eci, ecr});
    step();
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || bus.out_valid); i++) step();
    check("drain_empty", 66'(sb.size()), 66'd0);
    check("drain_idle", {65'd0, bus.out_valid}, 66'd0);
  endtask

  initial begin
    logic [31:0] sat_cr;
    logic [65:0] held;
    bit          stalled_prev;
    int          acc;
    int          cyc;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.conj_b = 1'b0;
    bus.ar = '0; bus.ai = '0; bus.br = '0; bus.bi = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset_outputs", {bus.ovf, bus.ci, bus.cr}, 66'd0);
    check("reset_out_valid", {65'd0, bus.out_valid}, 66'd0);
    check("reset_in_ready", {65'd0, bus.in_ready}, 66'd1);
    @(negedge clk);
    rst_n = 1'b1;

    directed("mul", 32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0,
             32'hFFFB0000, 32'h000A0000, 2'b00);
    directed("conj", 32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b1,
             32'h000B0000, 32'h00020000, 2'b00);
`ifdef CMULT_SAT_EN
    sat_cr = 32'h7FFFFFFF;
`else
    sat_cr = 32'h00010000;
`endif
    directed("ovf_re", 32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'h0, 1'b0, sat_cr, 32'h0, 2'b01);
    directed("floor_neg", 32'hFFFFFFFF, 32'h0, 32'h00000001, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h0, 2'b00);
    directed("floor_pos", 32'h00000001, 32'h0, 32'h00000001, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00);

    // Stream of 8 with a 5-cycle downstream stall once results are waiting.
    acc = 0; cyc = 0; stalled_prev = 1'b0; held = '0;
    while (acc < 8 && cyc < 40) begin
      bus.out_ready = !(cyc >= 4 && cyc < 9);
      drive_rand();
      bus.in_valid = 1'b1;
      #1;
      if (stalled_prev) check("stall_hold", {bus.ovf, bus.ci, bus.cr}, held);
      check("stall_in_ready", {65'd0, bus.in_ready}, {65'd0, !(bus.out_valid && !bus.out_ready)});
      stalled_prev = bus.out_valid && !bus.out_ready;
      held = {bus.ovf, bus.ci, bus.cr};
      step();
      if (last_acc) acc++;
      cyc++;
    end
    check("stream_accepted", 66'(acc), 66'd8);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 40; i++) begin
      drive_rand();
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 9) < 7;
      step();
    end
    drain();

    // Reset with three sets in flight.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      bus.in_valid = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {65'd0, bus.out_valid}, 66'd0);
    check("midreset_outputs", {bus.ovf, bus.ci, bus.cr}, 66'd0);
    check("midreset_in_ready", {65'd0, bus.in_ready}, 66'd1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("post_reset_idle", {65'd0, bus.out_valid}, 66'd0);
      step();
    end
    directed("after_reset", 32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000, 1'b0,
             32'hFFFB0000, 32'h000A0000, 2'b00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/complex_mult_pipe.md
COMPLEX_MULT_PIPE -- requirements
Module: complex_mult_pipe

Interface
REQ-001 Parameter W, default 32: signed fixed-point word width of every real and imaginary operand and result.
REQ-002 Parameter FRAC, default 16: fractional bits; format is Q(W-FRAC).FRAC, two's complement.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand set A, B and conj_b is presented.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 ar, ai, br, bi  input  W each  signed operands A = ar + j·ai, B = br + j·bi.
REQ-008 conj_b  input  1  when 1, compute A·conj(B), captured with the operands.
REQ-009 out_valid  output  1  cr, ci and ovf hold a valid result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 cr, ci  output  W each  signed real and imaginary result.
REQ-012 ovf  output  2  {imag overflow, real overflow} for the presented result.

Function
REQ-013 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready on a rising edge.
REQ-014 Pipeline: three register stages S1 (four full 2W-bit signed products ar·br, ai·bi, ar·bi, ai·br), S2 (2W+1-bit sums), S3 (scaled, range-checked output).
REQ-015 Latency: an operand set accepted at edge N appears on the outputs with out_valid=1 after edge N+3 when no stall occurs.
REQ-016 Stall: a global advance enable is active when out_valid==0 or out_ready==1; in_ready equals this enable combinationally.
REQ-017 With the enable inactive, every stage, including its valid bit and conj_b, holds its value; cr, ci and ovf stay stable while out_valid=1 and out_ready=0.
REQ-018 Each stage carries its own valid bit; bubbles propagate as valid=0 and are not collapsed.
REQ-019 conj_b=0: real = ar·br − ai·bi, imag = ar·bi + ai·br.
REQ-020 conj_b=1: real = ar·br + ai·bi, imag = ai·br − ar·bi.
REQ-021 S2 sums are computed at 2W+1 bits with no intermediate loss.
REQ-022 Scaling: arithmetic shift right by FRAC bits, truncation toward negative infinity, no rounding.
REQ-023 ovf[0]/ovf[1] set when the scaled real/imag value lies outside [−2^(W−1), 2^(W−1)−1], regardless of configuration.
REQ-024 In-range values pass through exactly; out-of-range handling is defined in Configuration.
REQ-025 Accept and deliver in the same cycle are permitted; sustained throughput is one result per cycle when out_ready stays 1.

Reset
REQ-026 While rst_n=0: all stage valid bits 0, out_valid=0, cr=0, ci=0, ovf=0, in_ready=1.
REQ-027 Reset asserted mid-operation discards all in-flight operand sets without producing any output.
REQ-028 After rst_n deasserts, the first transfer in may occur at the first rising edge.

Configuration
REQ-029 Macro CMULT_SAT_EN defined: out-of-range values saturate to 2^(W−1)−1 (positive) or −2^(W−1) (negative).
REQ-030 Macro CMULT_SAT_EN undefined: out-of-range values wrap (low W bits of the scaled value kept); ovf reporting is unchanged.

Verification (W=32, FRAC=16)
REQ-031 A=1+2j (0x00010000, 0x00020000), B=3+4j, conj_b=0 -> cr=0xFFFB0000, ci=0x000A0000, ovf=0, out_valid three edges after acceptance.
REQ-032 Same operands, conj_b=1 -> cr=0x000B0000, ci=0x00020000, ovf=0.
REQ-033 ar=br=0x7FFF0000, ai=bi=0 -> ovf=2'b01; cr=0x7FFFFFFF with CMULT_SAT_EN, cr=0x00010000 without it; ci=0.
REQ-034 ar=0xFFFFFFFF, br=0x00000001, ai=bi=0 -> cr=0xFFFFFFFF (floor); ar=br=0x00000001 -> cr=0x00000000.
REQ-035 Stream 8 operand sets with out_ready held 0 for 5 cycles mid-stream -> in_ready=0 exactly while out_valid=1 and out_ready=0, no result lost or duplicated, order preserved.
REQ-036 rst_n pulsed low with 3 sets in flight -> out_valid=0 immediately, no stale result emitted after release, next accepted set correct.
